// File: rtl/pipeline_step_ctrl.sv
// Run/step sequencer for the pipeline debug path: turns debug commands into the
// per-cycle o_step enable, drains in-flight instructions after a fetched HALT.
//
// state  | meaning
// IDLE   | paused, pipeline frozen, accepts RUN/STEP
// RUN    | free-running, o_step every cycle until STOP or HALT fetch
// STEP   | single o_step cycle, then back to IDLE with o_done
// DRAIN  | HALT seen, issuing DRAIN_CYCLES steps to retire in-flight work
// HALTED | terminal, only reset leaves
module pipeline_step_ctrl #(
  parameter int NBITS        = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  output logic             o_cmd_ready,
  input  logic             i_halt_fetched,
  output logic             o_step,
  output logic             o_busy,
  output logic             o_halted,
  output logic             o_done,
  output logic [NBITS-1:0] o_cycle_count,
  output logic [2:0]       o_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_STEP   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_STOP = 2'b11;

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  logic [2:0]       state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             done_q, done_d;
  logic [NBITS-1:0] count_q, count_d;
  logic             cmd_acc;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      drain_q <= '0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign cmd_acc = i_cmd_valid & o_cmd_ready;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_acc && i_cmd == CMD_RUN)       state_d = S_RUN;
        else if (cmd_acc && i_cmd == CMD_STEP) state_d = S_STEP;
      end
      S_RUN: begin
        // A HALT fetch outranks a simultaneous STOP; the STOP is simply consumed.
        if (i_halt_fetched) begin
          state_d = S_DRAIN;
          drain_d = DW'(DRAIN_CYCLES);
        end else if (cmd_acc && i_cmd == CMD_STOP) begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        if (i_halt_fetched) begin
          state_d = S_DRAIN;
          drain_d = DW'(DRAIN_CYCLES);
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q <= DW'(1)) begin
          state_d = S_HALTED;
          drain_d = '0;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      S_HALTED: state_d = S_HALTED;
      default: begin
        state_d = S_IDLE;
        drain_d = '0;
      end
    endcase
  end

  always_comb begin
    o_step      = 1'b0;
    o_busy      = 1'b0;
    o_halted    = 1'b0;
    o_cmd_ready = 1'b0;
    case (state_q)
      S_IDLE:   o_cmd_ready = 1'b1;
      S_RUN: begin
        o_step      = 1'b1;
        o_busy      = 1'b1;
        o_cmd_ready = 1'b1;
      end
      S_STEP, S_DRAIN: begin
        o_step = 1'b1;
        o_busy = 1'b1;
      end
      S_HALTED: begin
        o_halted    = 1'b1;
        o_cmd_ready = 1'b1;
      end
      default: o_cmd_ready = 1'b0;
    endcase
  end

  // Saturating count of stepped cycles.
  always_comb begin
    count_d = count_q;
    if (o_step && count_q != '1) count_d = count_q + NBITS'(1);
  end

  assign o_done        = done_q;
  assign o_cycle_count = count_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// Self-checking bench for pipeline_step_ctrl: directed scenarios plus random
// command/halt traffic against a behavioural model of the run/step sequencer.
module tb_pipeline_step_ctrl;

  localparam int D = 4;
  localparam bit [1:0] NOP = 2'b00, RUN = 2'b01, STEP = 2'b10, STOP = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic        halt = 1'b0;

  logic        ready, step, busy, halted, done;
  logic [31:0] cnt32;
  logic [2:0]  st;
  logic        ready4, step4, busy4, halted4, done4;
  logic [3:0]  cnt4;
  logic [2:0]  st4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_step_ctrl #(.NBITS(32), .DRAIN_CYCLES(D)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .o_cmd_ready(ready), .i_halt_fetched(halt), .o_step(step), .o_busy(busy),
    .o_halted(halted), .o_done(done), .o_cycle_count(cnt32), .o_state(st));

  pipeline_step_ctrl #(.NBITS(4), .DRAIN_CYCLES(D)) dut4 (
    .i_clk(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .o_cmd_ready(ready4), .i_halt_fetched(halt), .o_step(step4), .o_busy(busy4),
    .o_halted(halted4), .o_done(done4), .o_cycle_count(cnt4), .o_state(st4));

  // Behavioural model: activity flags, remaining drain steps, unbounded step count.
  bit     m_run, m_single, m_halted, m_done;
  int     m_drain;
  longint m_cnt;

  function automatic bit m_step();
    return m_run || m_single || (m_drain > 0);
  endfunction

  function automatic bit m_ready();
    return !(m_single || m_drain > 0);
  endfunction

  function automatic bit [2:0] m_state();
    if (m_halted) return 3'd4;
    if (m_drain > 0) return 3'd3;
    if (m_single) return 3'd2;
    if (m_run) return 3'd1;
    return 3'd0;
  endfunction

  function automatic void m_reset();
    m_run = 0; m_single = 0; m_halted = 0; m_done = 0; m_drain = 0; m_cnt = 0;
  endfunction

  function automatic void m_edge(input bit v, input bit [1:0] c, input bit h);
    bit stepping;
    bit acc;
    stepping = m_step();
    acc = v && m_ready();
    m_done = 0;
    if (m_halted) begin
    end else if (m_drain > 0) begin
      m_drain--;
      if (m_drain == 0) begin m_halted = 1; m_done = 1; end
    end else if (m_single) begin
      m_single = 0;
      if (h) m_drain = D; else m_done = 1;
    end else if (m_run) begin
      if (h) begin m_run = 0; m_drain = D; end
      else if (acc && c == STOP) m_run = 0;
    end else if (acc) begin
      if (c == RUN) m_run = 1;
      else if (c == STEP) m_single = 1;
    end
    if (stepping) m_cnt++;
  endfunction

  function automatic bit [46:0] exp_vec();
    longint c32, c4;
    c32 = (m_cnt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt;
    c4  = (m_cnt > 15) ? 15 : m_cnt;
    return {m_state(), m_step(), m_step(), m_halted, m_done, m_ready(),
            c32[31:0], c4[3:0], m_state()};
  endfunction

  function automatic bit [46:0] obs_vec();
    return {st, step, busy, halted, done, ready, cnt32, cnt4, st4};
  endfunction

  task automatic tick(input bit v, input bit [1:0] c, input bit h);
    cmd_valid = v; cmd = c; halt = h;
    @(posedge clk);
    m_edge(v, c, h);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    cmd_valid = 0; cmd = NOP; halt = 0;
    rst_n = 1'b0;
    m_reset();
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(3);
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL reset_values: got %h want %h", obs_vec(), exp_vec());
    end
    n_cmp++;
    if (st !== 3'd0 || step !== 1'b0 || ready !== 1'b1 || cnt32 !== 32'd0) begin
      n_bad++; $display("FAIL reset_fields: state=%0d step=%b ready=%b cnt=%0d want 0/0/1/0",
                        st, step, ready, cnt32);
    end
    tick(1, RUN, 0);
    tick(0, NOP, 0);
    n_cmp++;
    if (step !== 1'b1) begin
      n_bad++; $display("FAIL run_before_reset: step=%b want 1", step);
    end
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    n_cmp++;
    if (step !== 1'b0 || st !== 3'd0 || cnt32 !== 32'd0) begin
      n_bad++; $display("FAIL async_reset_mid_run: step=%b state=%0d cnt=%0d want 0/0/0",
                        step, st, cnt32);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_single_step();
    int steps = 0, dones = 0;
    do_reset(1);
    for (int k = 0; k < 3; k++) begin
      tick(1, STEP, 0);
      steps += step;
      n_cmp++;
      if (obs_vec() !== exp_vec() || ready !== 1'b0) begin
        n_bad++; $display("FAIL step_active: got %h want %h", obs_vec(), exp_vec());
      end
      tick(1, STEP, 0);
      dones += done;
      steps += step;
      n_cmp++;
      if (obs_vec() !== exp_vec() || done !== 1'b1 || ready !== 1'b1) begin
        n_bad++; $display("FAIL step_done: got %h want %h", obs_vec(), exp_vec());
      end
      tick(0, NOP, 0);
      dones += done;
    end
    n_cmp++;
    if (steps !== 3 || dones !== 3 || cnt32 !== 32'd3) begin
      n_bad++; $display("FAIL step_totals: steps=%0d dones=%0d cnt=%0d want 3/3/3",
                        steps, dones, cnt32);
    end
  endtask

  task automatic test_run_stop();
    int steps = 0;
    do_reset(1);
    tick(1, RUN, 0);
    for (int k = 0; k < 9; k++) begin
      steps += step;
      tick(k % 2, NOP, 0);
    end
    steps += step;
    tick(1, STOP, 0);
    n_cmp++;
    if (obs_vec() !== exp_vec() || steps !== 10 || cnt32 !== 32'd10 || st !== 3'd0) begin
      n_bad++; $display("FAIL run_stop: steps=%0d cnt=%0d state=%0d want 10/10/0",
                        steps, cnt32, st);
    end
    tick(1, RUN, 0);
    tick(0, NOP, 0);
    tick(1, STOP, 0);
    n_cmp++;
    if (obs_vec() !== exp_vec() || cnt32 !== 32'd12) begin
      n_bad++; $display("FAIL run_resume: cnt=%0d want 12", cnt32);
    end
  endtask

  task automatic test_halt_drain();
    int steps = 0, dones = 0, budget = 40;
    do_reset(1);
    tick(1, RUN, 0);
    for (int k = 1; k <= 6; k++) begin
      steps += step;
      tick(0, NOP, k == 6);
    end
    while (!halted && budget > 0) begin
      steps += step;
      tick(0, NOP, 1);
      dones += done;
      budget--;
    end
    n_cmp++;
    if (budget == 0 || steps !== 6 + D || dones !== 1 || cnt32 !== 32'(6 + D)) begin
      n_bad++; $display("FAIL halt_drain: steps=%0d dones=%0d cnt=%0d budget=%0d want %0d/1/%0d",
                        steps, dones, cnt32, budget, 6 + D, 6 + D);
    end
    for (int k = 0; k < 6; k++) begin
      tick(1, (k % 2) ? STEP : RUN, 0);
      dones += done;
      n_cmp++;
      if (obs_vec() !== exp_vec() || halted !== 1'b1 || step !== 1'b0) begin
        n_bad++; $display("FAIL halted_ignores: got %h want %h", obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (dones !== 1) begin
      n_bad++; $display("FAIL halt_done_once: dones=%0d want 1", dones);
    end
  endtask

  task automatic test_simultaneous();
    int steps;
    do_reset(1);
    tick(1, RUN, 0);
    tick(1, STOP, 1);
    n_cmp++;
    if (obs_vec() !== exp_vec() || st !== 3'd3) begin
      n_bad++; $display("FAIL stop_vs_halt: state=%0d want 3", st);
    end
    do_reset(1);
    tick(1, STEP, 0);
    tick(0, NOP, 1);
    steps = 0;
    for (int k = 0; k < D; k++) begin
      n_cmp++;
      if (st !== 3'd3 || step !== 1'b1) begin
        n_bad++; $display("FAIL step_halt_drain: cycle=%0d state=%0d step=%b want 3/1", k, st, step);
      end
      steps += step;
      tick(0, NOP, 1);
    end
    n_cmp++;
    if (obs_vec() !== exp_vec() || halted !== 1'b1 || done !== 1'b1 || steps !== D) begin
      n_bad++; $display("FAIL step_halt_end: halted=%b done=%b steps=%0d want 1/1/%0d",
                        halted, done, steps, D);
    end
  endtask

  task automatic test_saturation();
    do_reset(1);
    tick(1, RUN, 0);
    for (int k = 0; k < 19; k++) tick(0, NOP, 0);
    tick(1, STOP, 0);
    n_cmp++;
    if (cnt4 !== 4'd15 || cnt32 !== 32'd20 || obs_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL saturation: cnt4=%0d cnt32=%0d want 15/20", cnt4, cnt32);
    end
  endtask

  task automatic test_random();
    int halted_for = 0;
    do_reset(1);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 199) == 0 || halted_for > 4) begin
        do_reset(1);
        halted_for = 0;
      end
      tick($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 24) == 0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL random_cycle%0d: got %h want %h", k, obs_vec(), exp_vec());
      end
      halted_for = halted ? halted_for + 1 : 0;
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_single_step();
    test_run_stop();
    test_halt_drain();
    test_simultaneous();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
